// File: rtl/yukle_sakla_birimi.sv
// rtl/yukle_sakla_birimi.sv - load/store unit: aligns core requests onto a word-wide memory port
// Three-state handshake FSM; all memory-side and completion outputs are registered.
module yukle_sakla_birimi (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek_gecerli_i,
  output logic        istek_hazir_o,
  input  logic        yaz_i,
  input  logic [1:0]  boyut_i,
  input  logic        isaretsiz_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] veri_i,
  output logic        bellek_istek_o,
  output logic        bellek_yaz_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_veri_o,
  output logic [3:0]  bellek_maske_o,
  input  logic        bellek_gecerli_i,
  input  logic [31:0] bellek_veri_i,
  output logic [31:0] sonuc_o,
  output logic        sonuc_gecerli_o,
  output logic        hizasiz_hata_o,
  output logic        durdur_o
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    TAMAM = 2'd2
  } durum_t;

  durum_t      durum_q;
  logic        yaz_q;
  logic        isaretsiz_q;
  logic [1:0]  boyut_q;
  logic [1:0]  ofset_q;
  logic        bellek_istek_q;
  logic        bellek_yaz_q;
  logic [31:0] bellek_adres_q;
  logic [31:0] bellek_veri_q;
  logic [3:0]  bellek_maske_q;
  logic [31:0] sonuc_q;
  logic        sonuc_gecerli_q;
  logic        hizasiz_hata_q;

  logic        hizasiz_d;
  logic [3:0]  maske_d;
  logic [31:0] veri_d;
  logic [31:0] yuk_sonuc_d;
  logic [7:0]  bayt;
  logic [15:0] yarim;

  // Request decode from the live inputs; only consumed in the acceptance cycle.
  always_comb begin
    hizasiz_d = 1'b0;
    maske_d   = 4'b1111;
    veri_d    = 32'd0;
    case (boyut_i)
      2'b00:   hizasiz_d = 1'b0;
      2'b01:   hizasiz_d = adres_i[0];
      2'b10:   hizasiz_d = |adres_i[1:0];
      default: hizasiz_d = 1'b1;
    endcase
    if (yaz_i) begin
      case (boyut_i)
        2'b00: begin
          maske_d = 4'b0001 << adres_i[1:0];
          veri_d  = {4{veri_i[7:0]}};
        end
        2'b01: begin
          maske_d = 4'b0011 << adres_i[1:0];
          veri_d  = {2{veri_i[15:0]}};
        end
        default: begin
          maske_d = 4'b1111;
          veri_d  = veri_i;
        end
      endcase
    end
  end

  // Load lane selection uses the offset and size latched at acceptance.
  always_comb begin
    bayt        = 8'd0;
    yarim       = ofset_q[1] ? bellek_veri_i[31:16] : bellek_veri_i[15:0];
    yuk_sonuc_d = bellek_veri_i;
    case (ofset_q)
      2'd0:    bayt = bellek_veri_i[7:0];
      2'd1:    bayt = bellek_veri_i[15:8];
      2'd2:    bayt = bellek_veri_i[23:16];
      default: bayt = bellek_veri_i[31:24];
    endcase
    case (boyut_q)
      2'b00:   yuk_sonuc_d = {{24{~isaretsiz_q & bayt[7]}}, bayt};
      2'b01:   yuk_sonuc_d = {{16{~isaretsiz_q & yarim[15]}}, yarim};
      default: yuk_sonuc_d = bellek_veri_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      yaz_q           <= 1'b0;
      isaretsiz_q     <= 1'b0;
      boyut_q         <= 2'b00;
      ofset_q         <= 2'b00;
      bellek_istek_q  <= 1'b0;
      bellek_yaz_q    <= 1'b0;
      bellek_adres_q  <= 32'd0;
      bellek_veri_q   <= 32'd0;
      bellek_maske_q  <= 4'd0;
      sonuc_q         <= 32'd0;
      sonuc_gecerli_q <= 1'b0;
      hizasiz_hata_q  <= 1'b0;
    end else begin
      sonuc_gecerli_q <= 1'b0;
      hizasiz_hata_q  <= 1'b0;
      case (durum_q)
        BOSTA: begin
          if (istek_gecerli_i) begin
            yaz_q       <= yaz_i;
            isaretsiz_q <= isaretsiz_i;
            boyut_q     <= boyut_i;
            ofset_q     <= adres_i[1:0];
            if (hizasiz_d) begin
              durum_q        <= TAMAM;
              hizasiz_hata_q <= 1'b1;
              sonuc_q        <= 32'd0;
            end else begin
              durum_q        <= ISTEK;
              bellek_istek_q <= 1'b1;
              bellek_yaz_q   <= yaz_i;
              bellek_adres_q <= {adres_i[31:2], 2'b00};
              bellek_veri_q  <= veri_d;
              bellek_maske_q <= maske_d;
            end
          end
        end
        ISTEK: begin
          if (bellek_gecerli_i) begin
            durum_q         <= TAMAM;
            bellek_istek_q  <= 1'b0;
            bellek_yaz_q    <= 1'b0;
            sonuc_gecerli_q <= 1'b1;
            sonuc_q         <= yaz_q ? 32'd0 : yuk_sonuc_d;
          end
        end
        TAMAM:   durum_q <= BOSTA;
        default: durum_q <= BOSTA;
      endcase
    end
  end

  assign istek_hazir_o   = (durum_q == BOSTA);
  assign durdur_o        = (durum_q != BOSTA) | istek_gecerli_i;
  assign bellek_istek_o  = bellek_istek_q;
  assign bellek_yaz_o    = bellek_yaz_q;
  assign bellek_adres_o  = bellek_adres_q;
  assign bellek_veri_o   = bellek_veri_q;
  assign bellek_maske_o  = bellek_maske_q;
  assign sonuc_o         = sonuc_q;
  assign sonuc_gecerli_o = sonuc_gecerli_q;
  assign hizasiz_hata_o  = hizasiz_hata_q;

endmodule

// File: doc/yukle_sakla_birimi.md
YUKLE_SAKLA_BIRIMI -- requirements
Module: yukle_sakla_birimi

Interface
REQ-001 SHALL have ports, clock and reset first, one per line:
 clk_i  in  1  clock; all state updates on rising edge
 rst_i  in  1  reset; synchronous, active-high
 istek_gecerli_i  in  1  core load/store request valid
 istek_hazir_o  out  1  unit able to accept a request this cycle
 yaz_i  in  1  1 = store, 0 = load
 boyut_i  in  2  00 byte, 01 half, 10 word, 11 illegal
 isaretsiz_i  in  1  load zero-extends when 1, sign-extends when 0
 adres_i  in  32  byte address, driven from the ALU result
 veri_i  in  32  store data (rs2), right-aligned
 bellek_istek_o  out  1  memory request strobe
 bellek_yaz_o  out  1  memory write enable
 bellek_adres_o  out  32  word-aligned address, bits[1:0] = 00
 bellek_veri_o  out  32  lane-shifted store data
 bellek_maske_o  out  4  byte-lane enables
 bellek_gecerli_i  in  1  memory acknowledge; read data valid on a load
 bellek_veri_i  in  32  memory read word
 sonuc_o  out  32  load result, extended
 sonuc_gecerli_o  out  1  one-cycle completion pulse
 hizasiz_hata_o  out  1  one-cycle misaligned/illegal-size pulse
 durdur_o  out  1  pipeline stall request
REQ-002 SHALL use one clock and a synchronous, active-high reset.

Function
REQ-003 SHALL implement the FSM states BOSTA, ISTEK and TAMAM.
REQ-004 istek_hazir_o SHALL be 1 only in BOSTA.
REQ-005 In BOSTA with istek_gecerli_i=1, SHALL latch yaz_i, boyut_i, isaretsiz_i, adres_i and veri_i, then take one of two branches:
 - Aligned: next state ISTEK.
 - Misaligned or illegal: next state TAMAM with the error flag set.
REQ-006 Misaligned SHALL mean any one of: half with adres[0]=1; word with adres[1:0]!=00; boyut=11.
REQ-007 In ISTEK, bellek_istek_o SHALL be 1 and all bellek_* outputs SHALL be held stable until bellek_gecerli_i=1 is sampled; the unit then moves to TAMAM. Wait time is unbounded.
REQ-008 Store mask and data SHALL be set as follows:
 - Byte: mask = 0001<<adres[1:0]; data = {4{veri[7:0]}}.
 - Half: mask = 0011<<adres[1:0]; data = {2{veri[15:0]}}.
 - Word: mask = 1111; data = veri.
REQ-009 A load SHALL drive bellek_maske_o = 1111 and bellek_yaz_o = 0.
REQ-010 A load SHALL capture bellek_veri_i in the cycle bellek_gecerli_i=1, select the byte or half addressed by adres[1:0], and sign- or zero-extend it to 32 bits per isaretsiz_i. A word load SHALL pass the word unchanged.
REQ-011 In TAMAM, for exactly one cycle:
 - Success: sonuc_gecerli_o = 1.
 - Error: hizasiz_hata_o = 1 instead.
 The next state SHALL be BOSTA.
REQ-012 sonuc_o SHALL be the load result during TAMAM. It SHALL be 0 for stores and on error, and SHALL hold its last value otherwise.
REQ-013 Completion latency SHALL be:
 - Misaligned request: 1 cycle after acceptance.
 - Memory acknowledging in the first ISTEK cycle: acceptance cycle N, bellek_istek_o high in N+1, result in N+2.
REQ-014 durdur_o SHALL equal (state != BOSTA) OR (state == BOSTA AND istek_gecerli_i).
REQ-015 A request presented in TAMAM SHALL NOT be accepted. It SHALL be accepted in the following BOSTA cycle if still valid.
REQ-016 bellek_gecerli_i SHALL be ignored in BOSTA and TAMAM, and a spurious ack SHALL cause no output change.
REQ-017 A misaligned or illegal request SHALL NOT assert bellek_istek_o.

Reset
REQ-018 While rst_i=1 at a clock edge, the unit SHALL:
 - Enter BOSTA.
 - Drive to 0: sonuc_o, sonuc_gecerli_o, hizasiz_hata_o, bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o, bellek_maske_o.
 - Drive istek_hazir_o to 1 after release.
REQ-019 Reset in ISTEK or TAMAM SHALL abort the operation and drop bellek_istek_o in the cycle after the reset edge. It SHALL produce no completion pulse, and a later ack SHALL be ignored.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
 - Word load, adres=0x0000_1004, ack on the first ISTEK cycle with data 0xDEAD_BEEF -> bellek_adres_o=0x0000_1004, mask 1111, sonuc_o=0xDEAD_BEEF, sonuc_gecerli_o 2 cycles after acceptance.
 - Signed byte load, adres=0x0000_2003, bellek_veri_i=0x80FF_0000 -> sonuc_o=0xFFFF_FF80. The same with isaretsiz_i=1 -> 0x0000_0080.
 - Half store, adres=0x0000_3002, veri_i=0x1234_ABCD -> bellek_adres_o=0x0000_3000, mask 1100, bellek_veri_o=0xABCD_ABCD, bellek_yaz_o=1, hold 3 cycles until ack, then sonuc_gecerli_o pulse.
 - Word load, adres=0x0000_4002 -> hizasiz_hata_o one cycle after acceptance, bellek_istek_o never asserted, boyut_i=11 behaves the same.
 - Reset asserted during a 5-cycle wait in ISTEK -> bellek_istek_o=0 next cycle, no pulses, a late ack ignored, next request served normally.
 - Back-to-back requests held valid -> second accepted the cycle after TAMAM, and durdur_o high continuously throughout.
